// File: rtl/audio_sched_pkg.sv
// Shared types and constants for the ROM voice scheduler.
// Holds the slot FSM state enum, default parameters and accumulator sizing.
package audio_sched_pkg;

    typedef enum logic {
        IDLE,
        FETCH
    } state_t;

    localparam int DEF_NUM_VOICES = 4;
    localparam int DEF_PHASE_W    = 16;
    localparam int DEF_ROM_AW     = 8;
    localparam int DEF_ROM_DW     = 8;
    localparam int DEF_SAMPLE_DIV = 512;

    // Wide enough for NUM_VOICES full-scale ROM words.
    function automatic int acc_width(input int dw, input int nv);
        return dw + $clog2(nv);
    endfunction

    localparam int ACC_W = acc_width(DEF_ROM_DW, DEF_NUM_VOICES);

endpackage

// File: rtl/sample_tick_gen.sv
// Free-running sample-rate divider: counts 0..SAMPLE_DIV-1 and wraps.
// Ports: clk, reset (sync, active-high), tick (high while count is at its last value).
module sample_tick_gen #(
    parameter int SAMPLE_DIV = 512
) (
    input  logic clk,
    input  logic reset,
    output logic tick
);

    localparam int DW = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;

    logic [DW-1:0] div;

    assign tick = (div == DW'(SAMPLE_DIV - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            div <= '0;
        end else if (tick) begin
            div <= '0;
        end else begin
            div <= div + DW'(1);
        end
    end

endmodule

// File: rtl/rom_voice_scheduler.sv
// Time-shares one waveform ROM across NUM_VOICES phase-accumulator voices
// and emits one mixed sample per SAMPLE_DIV clocks.
// Ports: clk, reset (sync, active-high); cfg_* voice config write port;
// rom_addr/rom_data shared ROM; sample_out/sample_valid mixed output; busy.
module rom_voice_scheduler
    import audio_sched_pkg::*;
#(
    parameter int NUM_VOICES = DEF_NUM_VOICES,
    parameter int PHASE_W    = DEF_PHASE_W,
    parameter int ROM_AW     = DEF_ROM_AW,
    parameter int ROM_DW     = DEF_ROM_DW,
    parameter int SAMPLE_DIV = DEF_SAMPLE_DIV
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          cfg_we,
    input  logic [$clog2(NUM_VOICES)-1:0] cfg_voice,
    input  logic [PHASE_W-1:0]            cfg_inc,
    input  logic                          cfg_en,
    input  logic [1:0]                    cfg_atten,
    input  logic                          cfg_phase_clr,
    output logic [ROM_AW-1:0]             rom_addr,
    input  logic [ROM_DW-1:0]             rom_data,
    output logic [15:0]                   sample_out,
    output logic                          sample_valid,
    output logic                          busy
);

    localparam int SW = $clog2(NUM_VOICES);
    localparam int AW = acc_width(ROM_DW, NUM_VOICES);

    state_t state;
    state_t state_next;

    logic [SW-1:0]         slot;
    logic [AW-1:0]         acc;
    logic [AW-1:0]         contrib;
    logic [AW-1:0]         acc_sum;
    logic                  last;
    logic                  tick;

    logic [PHASE_W-1:0]    phase [NUM_VOICES];
    logic [PHASE_W-1:0]    inc   [NUM_VOICES];
    logic [1:0]            atten [NUM_VOICES];
    logic [NUM_VOICES-1:0] en;

    sample_tick_gen #(
        .SAMPLE_DIV(SAMPLE_DIV)
    ) u_tick (
        .clk  (clk),
        .reset(reset),
        .tick (tick)
    );

    // slot rests at 0 in IDLE, so the address then shows voice 0.
    assign rom_addr = phase[slot][PHASE_W-1 -: ROM_AW];
    assign acc_sum  = acc + contrib;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        busy       = 1'b0;
        last       = 1'b0;
        contrib    = '0;
        unique case (state)
            IDLE: begin
                if (tick) begin
                    state_next = FETCH;
                end
            end
            FETCH: begin
                busy = 1'b1;
                last = (slot == SW'(NUM_VOICES - 1));
                if (en[slot]) begin
                    contrib = AW'(rom_data >> atten[slot]);
                end
                if (last) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            slot         <= '0;
            acc          <= '0;
            sample_out   <= '0;
            sample_valid <= 1'b0;
            en           <= '0;
            for (int i = 0; i < NUM_VOICES; i++) begin
                phase[i] <= '0;
                inc[i]   <= '0;
                atten[i] <= '0;
            end
        end else begin
            sample_valid <= 1'b0;
            if (state == IDLE && tick) begin
                slot <= '0;
                acc  <= '0;
            end
            if (state == FETCH) begin
                acc  <= acc_sum;
                slot <= slot + SW'(1);
                if (last) begin
                    sample_out   <= 16'(acc_sum);
                    sample_valid <= 1'b1;
                end
            end
            for (int i = 0; i < NUM_VOICES; i++) begin
                if (state == FETCH && slot == SW'(i) && en[i]) begin
                    phase[i] <= phase[i] + inc[i];
                end
            end
            // Placed last so a write to the slot being fetched wins.
            if (cfg_we) begin
                inc[cfg_voice]   <= cfg_inc;
                en[cfg_voice]    <= cfg_en;
                atten[cfg_voice] <= cfg_atten;
                if (cfg_phase_clr) begin
                    phase[cfg_voice] <= '0;
                end
            end
        end
    end

endmodule

// File: tb/tb_rom_voice_scheduler.sv
// Scoreboard bench for rom_voice_scheduler with SAMPLE_DIV=16, 4 voices.
// ROM model: rom_data = 255 - rom_addr.
module tb_rom_voice_scheduler;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        cfg_we = 1'b0;
    logic [1:0]  cfg_voice = '0;
    logic [15:0] cfg_inc = '0;
    logic        cfg_en = 1'b0;
    logic [1:0]  cfg_atten = '0;
    logic        cfg_phase_clr = 1'b0;
    logic [7:0]  rom_addr;
    logic [7:0]  rom_data;
    logic [15:0] sample_out;
    logic        sample_valid;
    logic        busy;

    typedef struct {
        int cyc;
        int val;
    } exp_t;

    exp_t q[$];
    int   cyc;
    int   n_checks = 0;
    int   n_fail = 0;

    rom_voice_scheduler #(
        .NUM_VOICES(4),
        .PHASE_W   (16),
        .ROM_AW    (8),
        .ROM_DW    (8),
        .SAMPLE_DIV(16)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .cfg_we       (cfg_we),
        .cfg_voice    (cfg_voice),
        .cfg_inc      (cfg_inc),
        .cfg_en       (cfg_en),
        .cfg_atten    (cfg_atten),
        .cfg_phase_clr(cfg_phase_clr),
        .rom_addr     (rom_addr),
        .rom_data     (rom_data),
        .sample_out   (sample_out),
        .sample_valid (sample_valid),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    assign rom_data = 8'd255 - rom_addr;

    // Cycle index relative to the last reset edge.
    always @(posedge clk) begin
        if (reset) cyc <= 0;
        else       cyc <= cyc + 1;
    end

    task automatic chk(input string name, input int act, input int exp_v);
        n_checks++;
        if (act != exp_v) begin
            n_fail++;
            $display("FAIL %s at cyc %0d: got %0d expected %0d",
                     name, cyc, act, exp_v);
        end
    endtask

    // Monitor: pop and compare on every output pulse.
    always @(negedge clk) begin
        if (!reset && sample_valid) begin
            if (q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_pulse at cyc %0d: got value %0d expected no pulse",
                         cyc, sample_out);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("pulse_cycle", cyc, e.cyc);
                chk("sample_out", int'(sample_out), e.val);
            end
        end
    end

    task automatic push(input int c, input int v);
        exp_t e;
        e.cyc = c;
        e.val = v;
        q.push_back(e);
    endtask

    task automatic wait_cyc(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    task automatic wr(input int v, input int inc_v, input int en_v,
                      input int att_v, input int clr_v);
        cfg_voice     = 2'(v);
        cfg_inc       = 16'(inc_v);
        cfg_en        = 1'(en_v);
        cfg_atten     = 2'(att_v);
        cfg_phase_clr = 1'(clr_v);
        cfg_we        = 1'b1;
        @(negedge clk);
        cfg_we        = 1'b0;
        cfg_phase_clr = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset  = 1'b1;
        cfg_we = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("rst_sample_out", int'(sample_out), 0);
        chk("rst_valid", int'(sample_valid), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_rom_addr", int'(rom_addr), 0);
        reset = 1'b0;
    endtask

    task automatic drain(input string name, input int c);
        wait_cyc(c);
        chk(name, q.size(), 0);
        q.delete();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // 1: idle frames, pulse timing and busy window
        do_reset();
        push(20, 0);
        push(36, 0);
        push(52, 0);
        for (int c = 14; c <= 21; c++) begin
            wait_cyc(c);
            chk("busy_window", int'(busy), (c >= 16 && c <= 19) ? 1 : 0);
        end
        drain("t1_drain", 54);

        // 2: single voice stepping one ROM address per frame
        do_reset();
        wr(0, 16'h0100, 1, 0, 0);
        push(20, 255);
        push(36, 254);
        push(52, 253);
        drain("t2_drain", 54);

        // 3: four voices full scale, then voice2 attenuated by 2
        do_reset();
        for (int v = 0; v < 4; v++) wr(v, 0, 1, 0, 0);
        push(20, 1020);
        push(36, 1020);
        push(52, 828);
        wait_cyc(37);
        wr(2, 0, 1, 2, 0);
        drain("t3_drain", 54);

        // 4: half-cycle increment, phase wraps
        do_reset();
        wr(0, 16'h8000, 1, 0, 0);
        push(20, 255);
        push(36, 127);
        push(52, 255);
        wait_cyc(16);
        chk("t4_addr_f0", int'(rom_addr), 8'h00);
        wait_cyc(32);
        chk("t4_addr_f1", int'(rom_addr), 8'h80);
        wait_cyc(48);
        chk("t4_addr_f2", int'(rom_addr), 8'h00);
        drain("t4_drain", 54);

        // 5: phase clear written during voice1's own fetch
        do_reset();
        wr(1, 16'h0100, 1, 0, 0);
        push(20, 255);
        push(36, 254);
        push(52, 255);
        push(68, 253);
        wait_cyc(33);
        chk("t5_addr_before", int'(rom_addr), 1);
        wr(1, 16'h0200, 1, 0, 1);
        wait_cyc(49);
        chk("t5_addr_cleared", int'(rom_addr), 0);
        wait_cyc(65);
        chk("t5_addr_new_inc", int'(rom_addr), 2);
        drain("t5_drain", 70);

        // 6: reset during slot 2 aborts the frame
        do_reset();
        wr(0, 0, 1, 0, 0);
        push(20, 255);
        wait_cyc(30);
        chk("t6_hold", int'(sample_out), 255);
        wait_cyc(34);
        chk("t6_busy_slot2", int'(busy), 1);
        reset = 1'b1;
        @(negedge clk);
        chk("t6_abort_sample", int'(sample_out), 0);
        chk("t6_abort_busy", int'(busy), 0);
        chk("t6_abort_valid", int'(sample_valid), 0);
        chk("t6_abort_pending", q.size(), 0);
        reset = 1'b0;
        push(20, 0);
        drain("t6_drain", 23);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
